proc_control_unit: RTL and testbench
====================================

Name: proc_control_unit

Overview:
- Instruction-sequencing FSM for the 16-bit bus processor.
- Sits directly upstream of the 10-input bus multiplexer. Drives that multiplexer's one-hot select, plus the register, accumulator (A), result (G) and instruction-register (IR) load enables.
- Executes mv, mvi, add and sub in 2 to 4 cycles.
- Asserts Done on the final cycle of each instruction.

Parameters:
- none. The encoding is fixed by the 9-bit IR format III_XXX_YYY and the 10-bit bus select.

Ports:
- Clock  input  1  single system clock; all state updates on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Run  input  1  start request, sampled in T0.
- IR  input  9  current instruction from the external IR register: [8:6] opcode, [5:3] X, [2:0] Y.
- Gnz  input  1  G register nonzero flag; used only with CU_MVNZ_EN.
- bus_sel  output  10  one-hot bus-mux select: bit0..7 = R0..R7, bit8 = G, bit9 = Din.
- Rin  output  8  register load enables, one-hot or zero.
- IRin  output  1  IR load enable.
- Ain  output  1  A register load enable.
- Gin  output  1  G register load enable.
- AddSub  output  1  ALU mode: 0 = add, 1 = subtract.
- Done  output  1  instruction completes this cycle.

Behaviour:
- State register: 2 bits, states T0, T1, T2, T3, updated on rising Clock.
- Outputs are combinational decodes of state and IR; no added latency.
- bus_sel is exactly one-hot in every state and every cycle. It is never zero or multi-hot, because the downstream mux has no default arm.
- Default values whenever a state does not set a signal: bus_sel = 10'b1000000000 (Din), Rin = 0, IRin = 0, Ain = 0, Gin = 0, AddSub = 0, Done = 0.
- Reset (Resetn = 0):
  - State forces to T0 immediately, without waiting for Clock.
  - All outputs take their default values; IRin = 0 even if Run = 1.
  - Reset asserted mid-instruction aborts it; no further Rin, Ain or Gin pulses.
- T0:
  - IRin = Run.
  - Run = 1: go to T1. Run = 0: stay in T0.
- T1, decoded on opcode:
  - 000 mv: bus_sel = R[Y], Rin[X] = 1, Done = 1, go to T0.
  - 001 mvi: bus_sel = Din, Rin[X] = 1, Done = 1, go to T0.
  - 010 add or 011 sub: bus_sel = R[X], Ain = 1, go to T2.
  - 100..111: NOP. Done = 1, all other signals at default, go to T0.
- T2: bus_sel = R[Y], Gin = 1, AddSub = IR[6], go to T3.
- T3: bus_sel = G (bit8), Rin[X] = 1, Done = 1, go to T0.
- Run is ignored outside T0. A Run held high back-to-back starts the next fetch on the cycle after Done.
- X = Y is legal, e.g. add R2,R2 doubles R2. There is no special-casing.
- IR must be held stable from T1 through T3; the external IR register is loaded only by IRin in T0.
- The state register never reaches an unreachable encoding. A defensive default branch returns to T0 with default outputs.

Optional Feature:
- Macro: CU_MVNZ_EN.
- Defined: opcode 100 is mvnz Rx,Ry, evaluated in T1.
  - Gnz = 1: bus_sel = R[Y], Rin[X] = 1, Done = 1.
  - Gnz = 0: Done = 1 only.
  - Either case then goes to T0.
- Not defined: opcode 100 is a NOP like 101..111, and Gnz is unused.

Test Plan:
- Reset: Resetn low, Run = 1 -> bus_sel = 10'h200 and IRin = Rin = Ain = Gin = Done = 0; state remains T0 until Resetn is released.
- mv: Run = 1 at T0, IR = 000_011_101 -> T1 shows bus_sel = 10'h020, Rin = 8'h08, Done = 1; next cycle is T0.
- mvi: IR = 001_111_000 -> T1 shows bus_sel = 10'h200, Rin = 8'h80, Done = 1; total 2 cycles.
- sub: IR = 011_001_010 -> T1 bus_sel = 10'h002 with Ain = 1; T2 bus_sel = 10'h004 with Gin = 1, AddSub = 1; T3 bus_sel = 10'h100 with Rin = 8'h02, Done = 1.
- Abort: Resetn pulsed low asynchronously during T2 of an add -> state returns to T0 with no Gin and no Rin pulse afterwards; the next Run then fetches normally.
- Undefined opcode: IR = 100_000_001 -> without the macro, T1 gives Done = 1 and Rin = 0. With CU_MVNZ_EN, Gnz = 1 gives Rin = 8'h01 and bus_sel = 10'h002; Gnz = 0 gives Rin = 0.

Source files
------------

// File: rtl/proc_control_unit.sv
// proc_control_unit: instruction-sequencing FSM for the 16-bit bus processor.
// Fetch/decode control for mv, mvi, add and sub (2 to 4 cycles). It drives the
// one-hot select of the 10-input bus multiplexer and the register, A, G and IR
// load enables.
//
// Optional feature: define CU_MVNZ_EN to execute opcode 100 as mvnz Rx,Ry,
// which is a conditional move on the Gnz flag. When it is undefined, opcode 100
// is a NOP and Gnz is unused.
//
// Ports:
//   Clock    in   1   system clock; state updates on the rising edge
//   Resetn   in   1   asynchronous active-low reset
//   Run      in   1   start request, sampled only in T0
//   IR       in   9   instruction III_XXX_YYY: [8:6] opcode, [5:3] X, [2:0] Y
//   Gnz      in   1   G nonzero flag (mvnz only)
//   bus_sel  out  10  one-hot bus select: [7:0] R0..R7, [8] G, [9] Din
//   Rin      out  8   register load enables, one-hot or zero
//   IRin     out  1   IR load enable
//   Ain      out  1   A load enable
//   Gin      out  1   G load enable
//   AddSub   out  1   ALU mode: 0 add, 1 subtract
//   Done     out  1   instruction completes this cycle
//
// The outputs are combinational decodes of the state and IR. The datapath
// consumes them in the same cycle, so they are not registered.
module proc_control_unit (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    input  logic       Gnz,
    output logic [9:0] bus_sel,
    output logic [7:0] Rin,
    output logic       IRin,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       Done
);

    localparam int unsigned SEL_W   = 10;
    localparam int unsigned REG_N   = 8;
    localparam int unsigned SEL_G   = 8;
    localparam int unsigned SEL_DIN = 9;

    localparam logic [SEL_W-1:0] SEL_DIN_OH = SEL_W'(1) << SEL_DIN;
    localparam logic [SEL_W-1:0] SEL_G_OH   = SEL_W'(1) << SEL_G;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef CU_MVNZ_EN
    localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;

    assign opcode = IR[8:6];
    assign rx     = IR[5:3];
    assign ry     = IR[2:0];

`ifndef CU_MVNZ_EN
    // Gnz only feeds the conditional move.
    logic unused_gnz;
    assign unused_gnz = Gnz;
`endif

    // Bus-select one-hot for general register r (bits 0..7).
    function automatic logic [SEL_W-1:0] sel_reg(input logic [2:0] r);
        return SEL_W'(1) << r;
    endfunction

    // Register load enable one-hot for register r.
    function automatic logic [REG_N-1:0] rin_reg(input logic [2:0] r);
        return REG_N'(1) << r;
    endfunction

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next = state;
        bus_sel    = SEL_DIN_OH;
        Rin        = '0;
        IRin       = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AddSub     = 1'b0;
        Done       = 1'b0;

        // An asserted reset holds every output at its default, so Run cannot
        // raise IRin while the state register is still forced to T0.
        if (!Resetn) begin
            state_next = T0;
        end else begin
            unique case (state)
                T0: begin
                    IRin       = Run;
                    state_next = Run ? T1 : T0;
                end

                T1: begin
                    state_next = T0;
                    case (opcode)
                        OP_MV: begin
                            bus_sel = sel_reg(ry);
                            Rin     = rin_reg(rx);
                            Done    = 1'b1;
                        end
                        OP_MVI: begin
                            bus_sel = SEL_DIN_OH;
                            Rin     = rin_reg(rx);
                            Done    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            bus_sel    = sel_reg(rx);
                            Ain        = 1'b1;
                            state_next = T2;
                        end
`ifdef CU_MVNZ_EN
                        OP_MVNZ: begin
                            // If G is zero, finish without a register write. The bus
                            // stays on Din so that it remains one-hot.
                            if (Gnz) begin
                                bus_sel = sel_reg(ry);
                                Rin     = rin_reg(rx);
                            end
                            Done = 1'b1;
                        end
`endif
                        default: begin
                            Done = 1'b1;
                        end
                    endcase
                end

                T2: begin
                    bus_sel    = sel_reg(ry);
                    Gin        = 1'b1;
                    AddSub     = IR[6];
                    state_next = T3;
                end

                T3: begin
                    bus_sel    = SEL_G_OH;
                    Rin        = rin_reg(rx);
                    Done       = 1'b1;
                    state_next = T0;
                end

                default: begin
                    state_next = T0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Testbench for proc_control_unit. The stimulus process pushes the expected
// outputs for each cycle into a queue. The monitor pops one entry at every
// falling clock edge, or on a sample event raised during an asynchronous
// reset, and compares it with the DUT outputs.
module tb_proc_control_unit;

    logic       Clock;
    logic       Resetn;
    logic       Run;
    logic [8:0] IR;
    logic       Gnz;
    logic [9:0] bus_sel;
    logic [7:0] Rin;
    logic       IRin;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       Done;

    proc_control_unit dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .IR     (IR),
        .Gnz    (Gnz),
        .bus_sel(bus_sel),
        .Rin    (Rin),
        .IRin   (IRin),
        .Ain    (Ain),
        .Gin    (Gin),
        .AddSub (AddSub),
        .Done   (Done)
    );

    typedef struct {
        string      name;
        logic [9:0] sel;
        logic [7:0] rin;
        logic       irin;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       done;
    } exp_t;

    localparam logic [9:0] DIN = 10'h200;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    event sample_ev;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic exp_t mk(input string n, input logic [9:0] s, input logic [7:0] r,
                                input logic irin, input logic ain, input logic gin,
                                input logic as, input logic done);
        exp_t e;
        e.name = n; e.sel = s; e.rin = r; e.irin = irin;
        e.ain = ain; e.gin = gin; e.addsub = as; e.done = done;
        return e;
    endfunction

    // Monitor: compares one queued expectation for each sample point.
    initial begin
        forever begin
            @(negedge Clock or sample_ev);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (bus_sel !== e.sel || Rin !== e.rin || IRin !== e.irin || Ain !== e.ain ||
                    Gin !== e.gin || AddSub !== e.addsub || Done !== e.done) begin
                    errors++;
                    $display("FAIL %s: got sel=%h rin=%h irin=%b ain=%b gin=%b as=%b done=%b, want sel=%h rin=%h irin=%b ain=%b gin=%b as=%b done=%b",
                             e.name, bus_sel, Rin, IRin, Ain, Gin, AddSub, Done,
                             e.sel, e.rin, e.irin, e.ain, e.gin, e.addsub, e.done);
                end
            end
        end
    end

    // Applies inputs one time unit after a rising edge and queues the expected
    // outputs for that cycle.
    task automatic drive(input logic rst, input logic run, input logic [8:0] ir,
                         input logic gnz, input exp_t e);
        @(posedge Clock);
        #1;
        Resetn = rst; Run = run; IR = ir; Gnz = gnz;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string n);
        drive(1'b1, 1'b0, 9'b000_000_000, 1'b0, mk(n, DIN, 8'h00, 0, 0, 0, 0, 0));
    endtask

    initial begin
        Resetn = 1'b0; Run = 1'b1; IR = 9'b0; Gnz = 1'b0;

        // Reset is held with Run high, so IRin must stay low and the state stays at T0.
        drive(1'b0, 1'b1, 9'b0, 1'b0, mk("reset0", DIN, 8'h00, 0, 0, 0, 0, 0));
        drive(1'b0, 1'b1, 9'b0, 1'b0, mk("reset1", DIN, 8'h00, 0, 0, 0, 0, 0));
        idle("post_reset_idle");

        // mv R3,R5
        drive(1'b1, 1'b1, 9'b000_011_101, 1'b0, mk("mv_fetch", DIN, 8'h00, 1, 0, 0, 0, 0));
        drive(1'b1, 1'b0, 9'b000_011_101, 1'b0, mk("mv_t1", 10'h020, 8'h08, 0, 0, 0, 0, 1));
        idle("mv_after");

        // mvi R7 with Run held high. The second fetch follows Done directly.
        drive(1'b1, 1'b1, 9'b001_111_000, 1'b0, mk("mvi_fetch", DIN, 8'h00, 1, 0, 0, 0, 0));
        drive(1'b1, 1'b1, 9'b001_111_000, 1'b0, mk("mvi_t1", DIN, 8'h80, 0, 0, 0, 0, 1));
        drive(1'b1, 1'b1, 9'b011_001_010, 1'b0, mk("b2b_fetch", DIN, 8'h00, 1, 0, 0, 0, 0));

        // sub R1,R2
        drive(1'b1, 1'b0, 9'b011_001_010, 1'b0, mk("sub_t1", 10'h002, 8'h00, 0, 1, 0, 0, 0));
        drive(1'b1, 1'b0, 9'b011_001_010, 1'b0, mk("sub_t2", 10'h004, 8'h00, 0, 0, 1, 1, 0));
        drive(1'b1, 1'b0, 9'b011_001_010, 1'b0, mk("sub_t3", 10'h100, 8'h02, 0, 0, 0, 0, 1));
        idle("sub_after");

        // add R2,R2 (X = Y)
        drive(1'b1, 1'b1, 9'b010_010_010, 1'b0, mk("add_fetch", DIN, 8'h00, 1, 0, 0, 0, 0));
        drive(1'b1, 1'b0, 9'b010_010_010, 1'b0, mk("add_t1", 10'h004, 8'h00, 0, 1, 0, 0, 0));
        drive(1'b1, 1'b0, 9'b010_010_010, 1'b0, mk("add_t2", 10'h004, 8'h00, 0, 0, 1, 0, 0));
        drive(1'b1, 1'b0, 9'b010_010_010, 1'b0, mk("add_t3", 10'h100, 8'h04, 0, 0, 0, 0, 1));

        // Opcode 100 with Gnz = 1, then with Gnz = 0
        drive(1'b1, 1'b1, 9'b100_000_001, 1'b1, mk("op100_fetch_a", DIN, 8'h00, 1, 0, 0, 0, 0));
`ifdef CU_MVNZ_EN
        drive(1'b1, 1'b0, 9'b100_000_001, 1'b1, mk("mvnz_gnz1", 10'h002, 8'h01, 0, 0, 0, 0, 1));
`else
        drive(1'b1, 1'b0, 9'b100_000_001, 1'b1, mk("nop100_a", DIN, 8'h00, 0, 0, 0, 0, 1));
`endif
        drive(1'b1, 1'b1, 9'b100_000_001, 1'b0, mk("op100_fetch_b", DIN, 8'h00, 1, 0, 0, 0, 0));
        drive(1'b1, 1'b0, 9'b100_000_001, 1'b0, mk("op100_gnz0", DIN, 8'h00, 0, 0, 0, 0, 1));

        // Opcode 111 is always a NOP.
        drive(1'b1, 1'b1, 9'b111_101_011, 1'b1, mk("nop111_fetch", DIN, 8'h00, 1, 0, 0, 0, 0));
        drive(1'b1, 1'b0, 9'b111_101_011, 1'b1, mk("nop111_t1", DIN, 8'h00, 0, 0, 0, 0, 1));
        idle("nop_after");

        // Abort: reset is pulsed asynchronously in the middle of the T2 cycle of add R4,R6.
        drive(1'b1, 1'b1, 9'b010_100_110, 1'b0, mk("abort_fetch", DIN, 8'h00, 1, 0, 0, 0, 0));
        drive(1'b1, 1'b0, 9'b010_100_110, 1'b0, mk("abort_t1", 10'h010, 8'h00, 0, 1, 0, 0, 0));
        drive(1'b1, 1'b0, 9'b010_100_110, 1'b0, mk("abort_t2", 10'h040, 8'h00, 0, 0, 1, 0, 0));
        #6;
        Resetn = 1'b0;
        exp_q.push_back(mk("abort_async", DIN, 8'h00, 0, 0, 0, 0, 0));
        #1;
        -> sample_ev;
        drive(1'b0, 1'b1, 9'b010_100_110, 1'b0, mk("abort_held", DIN, 8'h00, 0, 0, 0, 0, 0));
        idle("abort_release");
        idle("abort_quiet");

        // A normal fetch after the abort
        drive(1'b1, 1'b1, 9'b000_000_111, 1'b0, mk("refetch", DIN, 8'h00, 1, 0, 0, 0, 0));
        drive(1'b1, 1'b0, 9'b000_000_111, 1'b0, mk("refetch_mv", 10'h080, 8'h01, 0, 0, 0, 0, 1));
        idle("final_idle");

        // Wait for the queue to drain, with a cycle budget.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge Clock);
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
